// File: rtl/ahb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_arbiter
//  Purpose  : Three-master AHB bus arbiter for the shared master-to-slave
//             path. Round-robin arbitration (starting after the last
//             winner) that respects fixed-length bursts, locked sequences
//             and undefined-length INCR bursts. An optional hold timeout
//             applies to undefined-length INCR. The arbiter parks on
//             default master 0 (all grants low) when nobody requests.
//
//  Ports    : HCLK                 bus clock
//             HRESETn              asynchronous active-low reset
//             HBUSREQ_M1..M3       bus requests
//             HLOCK_M1..M3         locked-transfer requests
//             HTRANS, HBURST       muxed control of the current owner
//             HREADY               shared transfer-done; all state holds when low
//             HGRANT_M1..M3        grants (one-hot or all zero)
//             HMASTER              registered address-phase owner (mux select)
//             HMASTLOCK            owner's transfer is locked
//
//  Params   : MAX_HOLD             INCR hold limit in cycles while others
//                                  request (0 = unlimited, legal 0..255)
//  Macros   : AHB_ARB_FIXED_PRI_EN fixed priority M1 > M2 > M3 replaces
//                                  round-robin when defined
//
//  Revision : 1.0  initial release
// ============================================================================

`ifndef AHB_TRANS_BITS
`define AHB_TRANS_BITS 2
`endif
`ifndef AHB_BURST_BITS
`define AHB_BURST_BITS 3
`endif
`ifndef AHB_MASTER_BITS
`define AHB_MASTER_BITS 2
`endif
`ifndef AHB_MASTER_0
`define AHB_MASTER_0 2'd0
`endif
`ifndef AHB_MASTER_1
`define AHB_MASTER_1 2'd1
`endif
`ifndef AHB_MASTER_2
`define AHB_MASTER_2 2'd2
`endif
`ifndef AHB_MASTER_3
`define AHB_MASTER_3 2'd3
`endif

module ahb_arbiter #(
    parameter int MAX_HOLD = 0
) (
    input  logic                         HCLK,
    input  logic                         HRESETn,
    input  logic                         HBUSREQ_M1,
    input  logic                         HBUSREQ_M2,
    input  logic                         HBUSREQ_M3,
    input  logic                         HLOCK_M1,
    input  logic                         HLOCK_M2,
    input  logic                         HLOCK_M3,
    input  logic [`AHB_TRANS_BITS-1:0]   HTRANS,
    input  logic [`AHB_BURST_BITS-1:0]   HBURST,
    input  logic                         HREADY,
    output logic                         HGRANT_M1,
    output logic                         HGRANT_M2,
    output logic                         HGRANT_M3,
    output logic [`AHB_MASTER_BITS-1:0]  HMASTER,
    output logic                         HMASTLOCK
);

    localparam logic [`AHB_TRANS_BITS-1:0] c_trans_idle   = `AHB_TRANS_BITS'(0);
    localparam logic [`AHB_TRANS_BITS-1:0] c_trans_busy   = `AHB_TRANS_BITS'(1);
    localparam logic [`AHB_TRANS_BITS-1:0] c_trans_nonseq = `AHB_TRANS_BITS'(2);
    localparam logic [`AHB_TRANS_BITS-1:0] c_trans_seq    = `AHB_TRANS_BITS'(3);
    localparam logic [`AHB_BURST_BITS-1:0] c_burst_incr   = `AHB_BURST_BITS'(1);
    localparam logic [7:0]                 c_max_hold     = 8'(MAX_HOLD);

    // Registered state
    logic [2:0]                  r_grant;       // {M3, M2, M1}
    logic [`AHB_MASTER_BITS-1:0] r_hmaster;
    logic                        r_hmastlock;
    logic [4:0]                  r_beats_left;
    logic [7:0]                  r_hold_cnt;
    logic                        r_incr_undef;  // last NONSEQ of the owner was INCR
`ifndef AHB_ARB_FIXED_PRI_EN
    logic [`AHB_MASTER_BITS-1:0] r_rr_last;
`endif

    // Combinational
    logic [2:0]                  w_req;
    logic [2:0]                  w_lock;
    logic [4:0]                  w_burst_last;
    logic [4:0]                  w_rem;
    logic                        w_in_incr;
    logic [`AHB_MASTER_BITS-1:0] w_grant_idx;
    logic                        w_owner_req;
    logic                        w_owner_lock;
    logic                        w_others_req;
    logic                        w_owner_is_master;
    logic                        w_timed_out;
    logic                        w_incr_hold;
    logic                        w_hold;
    logic [`AHB_MASTER_BITS-1:0] w_win_idx;
    logic [2:0]                  w_win_onehot;
    logic [2:0]                  w_next_grant;
    logic                        w_grant_change;

    assign w_req  = {HBUSREQ_M3, HBUSREQ_M2, HBUSREQ_M1};
    assign w_lock = {HLOCK_M3, HLOCK_M2, HLOCK_M1};

    // Burst length minus one
    always_comb begin
        case (HBURST)
            3'd2, 3'd3: w_burst_last = 5'd3;
            3'd4, 3'd5: w_burst_last = 5'd7;
            3'd6, 3'd7: w_burst_last = 5'd15;
            default:    w_burst_last = 5'd0;
        endcase
    end

    // Beats remaining after the current address phase
    always_comb begin
        case (HTRANS)
            c_trans_nonseq: w_rem = w_burst_last;
            c_trans_seq:    w_rem = (r_beats_left == 5'd0) ? 5'd0 : r_beats_left - 5'd1;
            c_trans_busy:   w_rem = r_beats_left;
            default:        w_rem = 5'd0;
        endcase
    end

    // Undefined-length INCR: a NONSEQ starts/ends it, IDLE ends it
    always_comb begin
        case (HTRANS)
            c_trans_nonseq: w_in_incr = (HBURST == c_burst_incr);
            c_trans_idle:   w_in_incr = 1'b0;
            default:        w_in_incr = r_incr_undef;
        endcase
    end

    always_comb begin
        case (r_grant)
            3'b001:  w_grant_idx = `AHB_MASTER_1;
            3'b010:  w_grant_idx = `AHB_MASTER_2;
            3'b100:  w_grant_idx = `AHB_MASTER_3;
            default: w_grant_idx = `AHB_MASTER_0;
        endcase
    end

    assign w_owner_req       = |(r_grant & w_req);
    assign w_owner_lock      = |(r_grant & w_lock);
    assign w_others_req      = |(~r_grant & w_req);
    // HTRANS only describes the grantee once it is the address-phase owner;
    // during a handover it still belongs to the previous master.
    assign w_owner_is_master = (r_hmaster == w_grant_idx) && (r_grant != 3'b000);
    assign w_timed_out       = (c_max_hold != 8'd0) && (r_hold_cnt >= c_max_hold);
    assign w_incr_hold       = w_in_incr && w_owner_req && w_owner_is_master && !w_timed_out;
    assign w_hold            = (w_rem != 5'd0) || w_owner_lock || w_incr_hold;

`ifdef AHB_ARB_FIXED_PRI_EN
    always_comb begin
        if (HBUSREQ_M1)      w_win_idx = `AHB_MASTER_1;
        else if (HBUSREQ_M2) w_win_idx = `AHB_MASTER_2;
        else if (HBUSREQ_M3) w_win_idx = `AHB_MASTER_3;
        else                 w_win_idx = `AHB_MASTER_0;
    end
`else
    function automatic logic [`AHB_MASTER_BITS-1:0] f_next(input logic [`AHB_MASTER_BITS-1:0] m);
        return (m == `AHB_MASTER_3) ? `AHB_MASTER_1 : m + `AHB_MASTER_BITS'(1);
    endfunction

    logic [`AHB_MASTER_BITS-1:0] w_c1, w_c2, w_c3;
    assign w_c1 = f_next(r_rr_last);
    assign w_c2 = f_next(w_c1);
    assign w_c3 = f_next(w_c2);

    // Candidates are visited in order starting right after the last winner
    always_comb begin
        if (w_req[w_c1 - `AHB_MASTER_BITS'(1)])      w_win_idx = w_c1;
        else if (w_req[w_c2 - `AHB_MASTER_BITS'(1)]) w_win_idx = w_c2;
        else if (w_req[w_c3 - `AHB_MASTER_BITS'(1)]) w_win_idx = w_c3;
        else                                         w_win_idx = `AHB_MASTER_0;
    end
`endif

    always_comb begin
        case (w_win_idx)
            `AHB_MASTER_1: w_win_onehot = 3'b001;
            `AHB_MASTER_2: w_win_onehot = 3'b010;
            `AHB_MASTER_3: w_win_onehot = 3'b100;
            default:       w_win_onehot = 3'b000;
        endcase
    end

    assign w_next_grant   = w_hold ? r_grant : w_win_onehot;
    assign w_grant_change = (w_next_grant != r_grant);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_grant      <= 3'b000;
            r_hmaster    <= `AHB_MASTER_0;
            r_hmastlock  <= 1'b0;
            r_beats_left <= 5'd0;
            r_hold_cnt   <= 8'd0;
            r_incr_undef <= 1'b0;
`ifndef AHB_ARB_FIXED_PRI_EN
            r_rr_last    <= `AHB_MASTER_3;
`endif
        end else if (HREADY) begin
            r_grant      <= w_next_grant;
            // Ownership follows the grant one HREADY cycle later
            r_hmaster    <= w_grant_idx;
            r_hmastlock  <= w_owner_lock;
            r_beats_left <= w_rem;
            r_incr_undef <= w_grant_change ? 1'b0 : w_in_incr;
            if (w_grant_change)
                r_hold_cnt <= 8'd0;
            else if (w_incr_hold && w_others_req && (r_hold_cnt != 8'hFF))
                r_hold_cnt <= r_hold_cnt + 8'd1;
`ifndef AHB_ARB_FIXED_PRI_EN
            if (!w_hold && (w_win_idx != `AHB_MASTER_0))
                r_rr_last <= w_win_idx;
`endif
        end
    end

    assign HGRANT_M1 = r_grant[0];
    assign HGRANT_M2 = r_grant[1];
    assign HGRANT_M3 = r_grant[2];
    assign HMASTER   = r_hmaster;
    assign HMASTLOCK = r_hmastlock;

endmodule
`default_nettype wire

// File: tb/tb_ahb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahb_arbiter
//  Purpose  : Scoreboard bench for ahb_arbiter. Two instances share all
//             inputs: u_dut0 (MAX_HOLD = 0) and u_dut5 (MAX_HOLD = 5).
//             The stimulus process pushes per-cycle expected outputs; a
//             monitor pops and compares them after each rising edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ahb_arbiter;

    logic       HCLK = 1'b0;
    logic       HRESETn;
    logic       HBUSREQ_M1, HBUSREQ_M2, HBUSREQ_M3;
    logic       HLOCK_M1, HLOCK_M2, HLOCK_M3;
    logic [1:0] HTRANS;
    logic [2:0] HBURST;
    logic       HREADY;

    logic [2:0] w_g0, w_g5;
    logic [1:0] w_hm0, w_hm5;
    logic       w_ml0, w_ml5;

    localparam logic [1:0] c_idle = 2'd0, c_nonseq = 2'd2, c_seq = 2'd3;
    localparam logic [2:0] c_single = 3'd0, c_incr = 3'd1, c_incr4 = 3'd3, c_incr8 = 3'd5;
    localparam logic [5:0] c_zero = 6'd0;

    always #5 HCLK = ~HCLK;

    ahb_arbiter #(.MAX_HOLD(0)) u_dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .HBUSREQ_M1(HBUSREQ_M1), .HBUSREQ_M2(HBUSREQ_M2), .HBUSREQ_M3(HBUSREQ_M3),
        .HLOCK_M1(HLOCK_M1), .HLOCK_M2(HLOCK_M2), .HLOCK_M3(HLOCK_M3),
        .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY),
        .HGRANT_M1(w_g0[0]), .HGRANT_M2(w_g0[1]), .HGRANT_M3(w_g0[2]),
        .HMASTER(w_hm0), .HMASTLOCK(w_ml0)
    );

    ahb_arbiter #(.MAX_HOLD(5)) u_dut5 (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .HBUSREQ_M1(HBUSREQ_M1), .HBUSREQ_M2(HBUSREQ_M2), .HBUSREQ_M3(HBUSREQ_M3),
        .HLOCK_M1(HLOCK_M1), .HLOCK_M2(HLOCK_M2), .HLOCK_M3(HLOCK_M3),
        .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY),
        .HGRANT_M1(w_g5[0]), .HGRANT_M2(w_g5[1]), .HGRANT_M3(w_g5[2]),
        .HMASTER(w_hm5), .HMASTLOCK(w_ml5)
    );

    typedef struct {
        string      nm;
        bit         c0;
        logic [5:0] e0;
        bit         c5;
        logic [5:0] e5;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Packs {grant M3..M1, HMASTER, HMASTLOCK}
    function automatic logic [5:0] f_e(input logic [2:0] g, input logic [1:0] m, input logic l);
        return {g, m, l};
    endfunction

    task automatic cmp(input string nm, input int dut, input logic [5:0] act, input logic [5:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d: got grant=%b master=%0d lock=%b, want grant=%b master=%0d lock=%b",
                     nm, dut, act[5:3], act[2:1], act[0], exp[5:3], exp[2:1], exp[0]);
        end
    endtask

    // Monitor: checks the one-hot invariant every cycle and pops one
    // scoreboard entry per rising edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge HCLK);
            #1;
            n_checks += 2;
            if (!$onehot0(w_g0)) begin
                n_errors++;
                $display("FAIL onehot dut0: got grant=%b, want at most one bit", w_g0);
            end
            if (!$onehot0(w_g5)) begin
                n_errors++;
                $display("FAIL onehot dut5: got grant=%b, want at most one bit", w_g5);
            end
            if (q.size() > 0) begin
                x = q.pop_front();
                if (x.c0) cmp(x.nm, 0, {w_g0, w_hm0, w_ml0}, x.e0);
                if (x.c5) cmp(x.nm, 5, {w_g5, w_hm5, w_ml5}, x.e5);
            end
        end
    end

    // Expectation for the outputs after the coming rising edge
    task automatic step2(input string nm, input logic [5:0] e0, input bit c5, input logic [5:0] e5);
        exp_t x;
        x.nm = nm; x.c0 = 1'b1; x.e0 = e0; x.c5 = c5; x.e5 = e5;
        q.push_back(x);
        @(negedge HCLK);
    endtask

    task automatic step(input string nm, input logic [5:0] e);
        step2(nm, e, 1'b1, e);
    endtask

    task automatic set_idle();
        HBUSREQ_M1 = 1'b0; HBUSREQ_M2 = 1'b0; HBUSREQ_M3 = 1'b0;
        HLOCK_M1   = 1'b0; HLOCK_M2   = 1'b0; HLOCK_M3   = 1'b0;
        HTRANS = c_idle; HBURST = c_single; HREADY = 1'b1;
    endtask

    task automatic do_reset();
        set_idle();
        HRESETn = 1'b0;
        step("reset", c_zero);
        HRESETn = 1'b1;
    endtask

    initial begin
        set_idle();
        HRESETn = 1'b0;
        step("rst_hold", c_zero);
        step("rst_hold", c_zero);
        HRESETn = 1'b1;
        for (int i = 0; i < 10; i++) step("idle_park", c_zero);

        // Sole requester M2
        HBUSREQ_M2 = 1'b1;
        step("m2_grant", f_e(3'b010, 2'd0, 1'b0));
        step("m2_owner", f_e(3'b010, 2'd2, 1'b0));
        HTRANS = c_nonseq; HBURST = c_single;
        for (int i = 0; i < 3; i++) step("m2_keep", f_e(3'b010, 2'd2, 1'b0));
        HBUSREQ_M2 = 1'b0; HTRANS = c_idle;
        step("m2_release", f_e(3'b000, 2'd2, 1'b0));
        step("park", c_zero);

        // All three request, SINGLE NONSEQ each cycle
        do_reset();
        HBUSREQ_M1 = 1'b1; HBUSREQ_M2 = 1'b1; HBUSREQ_M3 = 1'b1;
        HTRANS = c_nonseq; HBURST = c_single;
`ifdef AHB_ARB_FIXED_PRI_EN
        step("arb_1", f_e(3'b001, 2'd0, 1'b0));
        step("arb_2", f_e(3'b001, 2'd1, 1'b0));
        step("arb_3", f_e(3'b001, 2'd1, 1'b0));
        step("arb_4", f_e(3'b001, 2'd1, 1'b0));
        step("arb_5", f_e(3'b001, 2'd1, 1'b0));
`else
        step("arb_1", f_e(3'b001, 2'd0, 1'b0));
        step("arb_2", f_e(3'b010, 2'd1, 1'b0));
        step("arb_3", f_e(3'b100, 2'd2, 1'b0));
        step("arb_4", f_e(3'b001, 2'd3, 1'b0));
        step("arb_5", f_e(3'b010, 2'd1, 1'b0));
`endif

        // INCR4 with a stall; M1 drops its request mid-burst, M3 requests
        do_reset();
        HBUSREQ_M1 = 1'b1;
        step("m1_grant", f_e(3'b001, 2'd0, 1'b0));
        step("m1_owner", f_e(3'b001, 2'd1, 1'b0));
        HTRANS = c_nonseq; HBURST = c_incr4;
        step("incr4_b0", f_e(3'b001, 2'd1, 1'b0));
        HTRANS = c_seq; HBUSREQ_M1 = 1'b0; HBUSREQ_M3 = 1'b1;
        step("incr4_b1", f_e(3'b001, 2'd1, 1'b0));
        HREADY = 1'b0;
        step("incr4_stall", f_e(3'b001, 2'd1, 1'b0));
        HREADY = 1'b1;
        step("incr4_b2", f_e(3'b001, 2'd1, 1'b0));
        step("incr4_b3", f_e(3'b100, 2'd1, 1'b0));
        HTRANS = c_idle; HBURST = c_single;
        step("m3_owner", f_e(3'b100, 2'd3, 1'b0));
        step("m3_keep", f_e(3'b100, 2'd3, 1'b0));

        // Locked sequence by M2 while M1 requests
        do_reset();
        HBUSREQ_M2 = 1'b1; HLOCK_M2 = 1'b1;
        step("lock_grant", f_e(3'b010, 2'd0, 1'b0));
        step("lock_owner", f_e(3'b010, 2'd2, 1'b1));
        HBUSREQ_M1 = 1'b1; HTRANS = c_nonseq; HBURST = c_single;
        for (int i = 0; i < 3; i++) step("lock_keep", f_e(3'b010, 2'd2, 1'b1));
        HLOCK_M2 = 1'b0; HBUSREQ_M2 = 1'b0; HTRANS = c_idle;
        step("unlock_move", f_e(3'b001, 2'd2, 1'b0));
        step("unlock_m1_owner", f_e(3'b001, 2'd1, 1'b0));

        // Undefined INCR by M1 with M2 requesting: timeout vs unlimited
        do_reset();
        HBUSREQ_M1 = 1'b1;
        step("incr_grant", f_e(3'b001, 2'd0, 1'b0));
        step("incr_owner", f_e(3'b001, 2'd1, 1'b0));
        HTRANS = c_nonseq; HBURST = c_incr; HBUSREQ_M2 = 1'b1;
        step("incr_hold", f_e(3'b001, 2'd1, 1'b0));
        HTRANS = c_seq;
        for (int i = 0; i < 4; i++) step("incr_hold", f_e(3'b001, 2'd1, 1'b0));
        step2("incr_timeout", f_e(3'b001, 2'd1, 1'b0), 1'b1, f_e(3'b010, 2'd1, 1'b0));
        for (int i = 0; i < 50; i++) step2("incr_unlimited", f_e(3'b001, 2'd1, 1'b0), 1'b0, c_zero);

        // Reset in the middle of an INCR8 burst
        do_reset();
        HBUSREQ_M1 = 1'b1;
        step("rb_grant", f_e(3'b001, 2'd0, 1'b0));
        step("rb_owner", f_e(3'b001, 2'd1, 1'b0));
        HTRANS = c_nonseq; HBURST = c_incr8;
        step("rb_b0", f_e(3'b001, 2'd1, 1'b0));
        HTRANS = c_seq;
        step("rb_b1", f_e(3'b001, 2'd1, 1'b0));
        HRESETn = 1'b0;
        step("reset_mid", c_zero);
        HRESETn = 1'b1; HBUSREQ_M3 = 1'b1;
        step("post_reset", f_e(3'b001, 2'd0, 1'b0));

        set_idle();
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending entries, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
